// File: rtl/tsc_sequencer.sv
// tsc_sequencer: multi-cycle FETCH/DECODE/EXEC/WB control sequencer owning PC, IR and retired count
module tsc_sequencer #(
   parameter int WORD_SIZE = 16,
   parameter int PC_SIZE   = 8
) (
   input  logic                 clk,
   input  logic                 reset_cpu_n,
   input  logic                 cpu_enable,
   input  logic                 wwd_enable,
   input  logic                 imem_ack,
   input  logic [WORD_SIZE-1:0] imem_data,
   output logic                 imem_req,
   output logic [PC_SIZE-1:0]   imem_addr,
   output logic [PC_SIZE-1:0]   pc,
   output logic [WORD_SIZE-1:0] ir,
   output logic                 rdst,
   output logic                 alus,
   output logic                 lhi,
   output logic                 regw,
   output logic                 wwd,
   output logic [WORD_SIZE-1:0] num_inst,
   output logic [1:0]           state
);
   typedef enum logic [1:0] {FETCH = 2'd0, DECODE = 2'd1, EXEC = 2'd2, WB = 2'd3} state_t;
   state_t               state_q, state_d;
   logic [PC_SIZE-1:0]   pc_q, pc_d;
   logic [WORD_SIZE-1:0] ir_q, ir_d;
   logic [WORD_SIZE-1:0] num_q, num_d;
   logic [3:0]           opcode;
   logic [5:0]           func;
   logic                 is_add, is_wwd, is_adi, is_lhi, is_jmp, in_fetch, in_wb, fetch_hit;
   assign opcode    = ir_q[WORD_SIZE-1 -: 4];
   assign func      = ir_q[5:0];
   assign is_add    = (opcode == 4'hF) && (func == 6'h00);
   assign is_wwd    = (opcode == 4'hF) && (func == 6'h1C);
   assign is_adi    = opcode == 4'h4;
   assign is_lhi    = opcode == 4'h6;
   assign is_jmp    = opcode == 4'h9;
   assign in_fetch  = state_q == FETCH;
   assign in_wb     = cpu_enable && (state_q == WB);
   assign fetch_hit = imem_req && imem_ack;
   always_ff @(posedge clk or negedge reset_cpu_n) begin
      if (!reset_cpu_n) begin
         state_q <= FETCH;
         pc_q    <= '0;
         ir_q    <= '0;
         num_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         num_q   <= num_d;
      end
   end
   always_comb begin
      state_d = state_q;
      if (cpu_enable) begin
         case (state_q)
            FETCH:   state_d = fetch_hit ? DECODE : FETCH;
            DECODE:  state_d = EXEC;
            EXEC:    state_d = WB;
            default: state_d = FETCH;
         endcase
      end
   end
   // pc wraps modulo 2^PC_SIZE and the JMP target is the low PC_SIZE bits of ir
   always_comb begin
      ir_d  = (in_fetch && fetch_hit) ? imem_data : ir_q;
      pc_d  = in_wb ? (is_jmp ? ir_q[PC_SIZE-1:0] : pc_q + 1'b1) : pc_q;
      num_d = in_wb ? num_q + 1'b1 : num_q;
   end
   // reset gating keeps the request low while reset is held even though state reads FETCH
   always_comb begin
      imem_req  = reset_cpu_n && cpu_enable && in_fetch;
      imem_addr = pc_q;
      rdst      = !in_fetch && is_add;
      alus      = !in_fetch && is_adi;
      lhi       = !in_fetch && is_lhi;
      regw      = reset_cpu_n && in_wb && (is_add || is_adi || is_lhi);
      wwd       = reset_cpu_n && in_wb && is_wwd && wwd_enable;
   end
   assign pc       = pc_q;
   assign ir       = ir_q;
   assign num_inst = num_q;
   assign state    = state_q;
endmodule

// File: tb/tb_tsc_sequencer.sv
// tb_tsc_sequencer: table-driven instruction vectors plus freeze and reset-abort sequences
module tb_tsc_sequencer;
   logic        clk = 1'b0;
   logic        reset_cpu_n = 1'b0;
   logic        cpu_enable = 1'b1;
   logic        wwd_enable = 1'b1;
   logic        imem_ack = 1'b0;
   logic [15:0] imem_data = 16'h0;
   logic        imem_req, rdst, alus, lhi, regw, wwd;
   logic [7:0]  imem_addr, pc;
   logic [15:0] ir, num_inst;
   logic [1:0]  state;
   int          n_vec = 0;
   int          n_bad = 0;
   logic [7:0]  cur_pc = 8'h00;
   logic [15:0] cur_ir = 16'h0;
   typedef struct {
      logic [15:0] instr;
      logic        wen;
      int          dly;
      logic        rdst, alus, lhi, regw, wwd;
      logic [7:0]  pc;
      logic [15:0] num;
   } vec_t;
   vec_t tbl[12];
   tsc_sequencer dut (
      .clk(clk), .reset_cpu_n(reset_cpu_n), .cpu_enable(cpu_enable), .wwd_enable(wwd_enable),
      .imem_ack(imem_ack), .imem_data(imem_data), .imem_req(imem_req), .imem_addr(imem_addr),
      .pc(pc), .ir(ir), .rdst(rdst), .alus(alus), .lhi(lhi), .regw(regw), .wwd(wwd),
      .num_inst(num_inst), .state(state)
   );
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   // entered just after a falling edge with the sequencer in FETCH
   task automatic run_vec(input vec_t v);
      for (int d = 0; d <= v.dly; d++) begin
         chk("fetch_state", 32'(state), 0);
         chk("fetch_req", 32'(imem_req), 1);
         chk("fetch_addr", 32'(imem_addr), 32'(cur_pc));
         chk("fetch_ir_hold", 32'(ir), 32'(cur_ir));
         chk("fetch_strobes", 32'({rdst, alus, lhi, regw, wwd}), 0);
         imem_ack   = (d == v.dly);
         imem_data  = (d == v.dly) ? v.instr : 16'hBEEF;
         wwd_enable = v.wen;
         @(negedge clk);
      end
      imem_ack = 1'b0;
      for (int s = 1; s <= 3; s++) begin
         chk("seq_state", 32'(state), 32'(s));
         chk("seq_ir", 32'(ir), 32'(v.instr));
         chk("seq_sel", 32'({rdst, alus, lhi}), 32'({v.rdst, v.alus, v.lhi}));
         chk("seq_regw", 32'(regw), 32'((s == 3) && v.regw));
         chk("seq_wwd", 32'(wwd), 32'((s == 3) && v.wwd));
         chk("seq_req", 32'(imem_req), 0);
         @(negedge clk);
      end
      chk("next_state", 32'(state), 0);
      chk("next_pc", 32'(pc), 32'(v.pc));
      chk("next_addr", 32'(imem_addr), 32'(v.pc));
      chk("next_num", 32'(num_inst), 32'(v.num));
      cur_pc = v.pc;
      cur_ir = v.instr;
   endtask
   initial begin
      //          instr    wen dly rdst alus lhi regw wwd  pc     num
      tbl[0]  = '{16'h6101, 1, 0, 0, 0, 1, 1, 0, 8'h01, 16'd1};
      tbl[1]  = '{16'hF6C0, 1, 0, 1, 0, 0, 1, 0, 8'h02, 16'd2};
      tbl[2]  = '{16'hF81C, 1, 0, 0, 0, 0, 0, 1, 8'h03, 16'd3};
      tbl[3]  = '{16'hF81C, 0, 0, 0, 0, 0, 0, 0, 8'h04, 16'd4};
      tbl[4]  = '{16'h4A05, 1, 0, 0, 1, 0, 1, 0, 8'h05, 16'd5};
      tbl[5]  = '{16'h9010, 1, 0, 0, 0, 0, 0, 0, 8'h10, 16'd6};
      tbl[6]  = '{16'h9015, 1, 0, 0, 0, 0, 0, 0, 8'h15, 16'd7};
      tbl[7]  = '{16'h0000, 1, 3, 0, 0, 0, 0, 0, 8'h16, 16'd8};
      tbl[8]  = '{16'hF6C1, 1, 0, 0, 0, 0, 0, 0, 8'h17, 16'd9};
      tbl[9]  = '{16'h90FF, 1, 0, 0, 0, 0, 0, 0, 8'hFF, 16'd10};
      tbl[10] = '{16'h0000, 1, 0, 0, 0, 0, 0, 0, 8'h00, 16'd11};
      tbl[11] = '{16'h7123, 1, 1, 0, 0, 0, 0, 0, 8'h01, 16'd12};
      #1;
      chk("rst_state", 32'(state), 0);
      chk("rst_pc", 32'(pc), 0);
      chk("rst_ir", 32'(ir), 0);
      chk("rst_num", 32'(num_inst), 0);
      chk("rst_req", 32'(imem_req), 0);
      chk("rst_strobes", 32'({regw, wwd}), 0);
      repeat (2) @(negedge clk);
      reset_cpu_n = 1'b1;
      #1 chk("rel_req", 32'(imem_req), 1);
      for (int i = 0; i < 12; i++) run_vec(tbl[i]);
      // freeze in FETCH: stray ack is ignored, then re-requested
      cpu_enable = 1'b0;
      imem_ack   = 1'b1;
      imem_data  = 16'hF6C0;
      #1 chk("frz_fetch_req", 32'(imem_req), 0);
      @(negedge clk);
      chk("frz_fetch_state", 32'(state), 0);
      chk("frz_fetch_ir", 32'(ir), 32'(cur_ir));
      cpu_enable = 1'b1;
      #1 chk("refetch_req", 32'(imem_req), 1);
      @(negedge clk);
      chk("refetch_state", 32'(state), 1);
      chk("refetch_ir", 32'(ir), 32'h0000F6C0);
      imem_ack = 1'b0;
      @(negedge clk);
      chk("exec_state", 32'(state), 2);
      cpu_enable = 1'b0;
      imem_ack   = 1'b1;
      imem_data  = 16'hBEEF;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("frz_state", 32'(state), 2);
         chk("frz_ir", 32'(ir), 32'h0000F6C0);
         chk("frz_pc", 32'(pc), 32'h01);
         chk("frz_num", 32'(num_inst), 32'd12);
         chk("frz_rdst", 32'(rdst), 1);
         chk("frz_strobes", 32'({imem_req, regw, wwd}), 0);
      end
      cpu_enable = 1'b1;
      imem_ack   = 1'b0;
      @(negedge clk);
      chk("resume_state", 32'(state), 3);
      chk("resume_regw", 32'(regw), 1);
      @(negedge clk);
      chk("resume_pc", 32'(pc), 32'h02);
      chk("resume_num", 32'(num_inst), 32'd13);
      // reset asserted during WB aborts the instruction
      imem_ack  = 1'b1;
      imem_data = 16'h4A05;
      @(negedge clk);
      imem_ack = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("abort_wb_state", 32'(state), 3);
      chk("abort_wb_regw", 32'(regw), 1);
      reset_cpu_n = 1'b0;
      #1;
      chk("abort_regw", 32'(regw), 0);
      chk("abort_state", 32'(state), 0);
      chk("abort_pc", 32'(pc), 0);
      chk("abort_ir", 32'(ir), 0);
      chk("abort_num", 32'(num_inst), 0);
      chk("abort_out", 32'({imem_req, alus, wwd}), 0);
      @(negedge clk);
      chk("abort_hold_num", 32'(num_inst), 0);
      reset_cpu_n = 1'b1;
      #1 chk("restart_req", 32'(imem_req), 1);
      chk("restart_addr", 32'(imem_addr), 0);
      cur_pc = 8'h00;
      cur_ir = 16'h0000;
      run_vec(tbl[0]);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/tsc_sequencer.md
# tsc_sequencer

Multi-cycle control sequencer for the TSC CPU datapath. It owns the PC and instruction register. It fetches each instruction from instruction memory over a req/ack handshake, then decodes it and drives the register-file and ALU control strobes (RegDst, ALUSrc, LHI, RegWrite, WWD) in a fixed FETCH→DECODE→EXEC→WB sequence. It sits between the instruction memory and the registers/ALU/sign-extend datapath, and it replaces the single-cycle combinational control.

## Interface
- WORD_SIZE, 16, instruction/data width
- PC_SIZE, 8, PC width
- clk  in  1  system clock, all state on rising edge
- reset_cpu_n  in  1  asynchronous, active-low reset
- cpu_enable  in  1  0 = freeze sequencer (state, PC, IR, counter held)
- wwd_enable  in  1  gates the wwd strobe
- imem_ack  in  1  memory has valid imem_data this cycle
- imem_data  in  WORD_SIZE  fetched instruction word
- imem_req  out  1  fetch request
- imem_addr  out  PC_SIZE  fetch address (= pc)
- pc  out  PC_SIZE  current PC
- ir  out  WORD_SIZE  latched instruction
- rdst, alus, lhi  out  1 each  datapath selects for current instruction
- regw  out  1  register-file write strobe (one-cycle pulse)
- wwd  out  1  output-port capture strobe (one-cycle pulse)
- num_inst  out  WORD_SIZE  retired-instruction count
- state  out  2  FSM state: FETCH=0, DECODE=1, EXEC=2, WB=3

## Operation
- Decode from ir:
  - ADD: opcode 4'hF, func 6'h00. Sets rdst=1, regw in WB.
  - WWD: opcode 4'hF, func 6'h1C. Sets wwd in WB.
  - ADI: opcode 4'h4. Sets alus=1, regw in WB.
  - LHI: opcode 4'h6. Sets lhi=1, regw in WB.
  - JMP: opcode 4'h9. Sets pc <= ir[PC_SIZE-1:0] in WB.
  - Any other encoding is a NOP: no strobes, PC advances, still counted.
- FETCH:
  - imem_req = cpu_enable, imem_addr = pc.
  - Stay in FETCH until imem_ack is sampled high with imem_req high.
  - On that edge: ir <= imem_data and go to DECODE.
- DECODE → EXEC → WB: one cycle each, unconditional. rdst/alus/lhi are valid (decoded from ir) in DECODE, EXEC and WB, and are 0 in FETCH.
- WB:
  - regw=1 for ADD/ADI/LHI.
  - wwd=1 for WWD only if wwd_enable=1.
  - pc <= JMP ? ir[7:0] : pc+1.
  - num_inst <= num_inst+1.
  - Next state is FETCH.
- cpu_enable=0 (any state):
  - State, pc, ir and num_inst are held.
  - imem_req, regw and wwd are forced 0; imem_ack is ignored.
  - When cpu_enable returns to 1, the FSM resumes in the held state. An ack dropped during FETCH is simply re-requested.
- Arithmetic:
  - pc+1 is modulo 2^PC_SIZE (8'hFF → 8'h00).
  - num_inst wraps 16'hFFFF → 16'h0000.
  - JMP target truncated to the low PC_SIZE bits.

## Timing
- Reset (reset_cpu_n=0, asynchronous):
  - Immediately: state=FETCH, pc=0, ir=0, num_inst=0.
  - imem_req, regw and wwd are 0 while reset is held.
- Reset mid-instruction aborts it: no regw/wwd pulse and no count.
- imem_req is combinational from state and cpu_enable. It is asserted in the first FETCH cycle after reset release.
- imem_req stays high and imem_addr stays stable until ack. An ack while imem_req=0 is ignored.
- Latency: an instruction takes 3 + (FETCH cycles) cycles. Minimum is 4 cycles, with ack in the first FETCH cycle.
- regw and wwd are asserted exactly one cycle, in WB. The datapath commits the register write on the WB→FETCH edge.
- The pc/num_inst update is visible in the cycle after WB, i.e. the first FETCH cycle of the next instruction, which already addresses the new pc.

## Test plan
- Reset, then fetch 16'h6101 (LHI) with immediate ack:
  - States 0,1,2,3.
  - lhi=1 in cycles 2–4, regw pulses in WB.
  - Then pc=1, num_inst=1.
- ADD 16'hF6C0, then WWD 16'hF81C with wwd_enable=1, then WWD again with wwd_enable=0:
  - ADD: rdst=1 and regw pulse.
  - First WWD: one wwd pulse.
  - Second WWD: no pulse, num_inst still increments.
- JMP 16'h9015 at pc=16:
  - pc=8'h15 after WB, next imem_addr=21, no regw.
- Ack delayed 3 cycles:
  - FETCH lasts 4 cycles with imem_addr stable.
  - ir updates only on the ack edge; instruction completes in 7 cycles.
- cpu_enable=0 for 5 cycles during EXEC, with a stray imem_ack:
  - All outputs held; no strobes.
  - Resumes to WB on re-enable.
- Edge cases:
  - pc=8'hFF plus NOP 16'h0000 → pc=8'h00.
  - num_inst preset path to 16'hFFFF → 0.
  - reset_cpu_n low during WB → no regw, all outputs zero, restart at pc 0.
